uart_rx_byte: RTL and testbench

Receive-side counterpart of the team's 8N1 UART transmitter. Samples the serial line on `clk_50M`, validates the start bit, recovers 8 data bits LSB-first using a 3-sample majority vote at mid-bit, and checks the stop bit. Completed bytes go into a one-entry holding register with a valid/read handshake, plus framing-error and overrun reporting. The block sits between the board RX pin and the byte consumer (command parser / loopback to the TX block).

---
 rtl/uart_rx_byte.sv | 131 +++++++++++++
 tb/tb_uart_rx_byte.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchronizer, 3-sample mid-bit majority vote,
// one-entry holding register with valid/read handshake, framing and overrun pulses.
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clk_50M,
    input  logic       reset_n,
    input  logic       uart_rxd,
    input  logic       rx_read,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
    localparam logic [CW-1:0] CNT_VOTE = CW'(HALF + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state, state_nx;
    logic          sync1, rxd_s;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          smp0, smp1;
    logic [7:0]    shreg;
    logic          vote, at_vote, at_last;
    logic          shift_en, load_byte, frame_bad;

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= uart_rxd;
            rxd_s <= sync1;
        end
    end

    // The third sample is the current rxd_s, so the vote resolves at the edge ending cnt==HALF+1.
    assign vote    = (smp0 & smp1) | (smp0 & rxd_s) | (smp1 & rxd_s);
    assign at_vote = (cnt == CNT_VOTE);
    assign at_last = (cnt == CNT_LAST);

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (!rxd_s) state_nx = S_START;
            S_START: begin
                if (at_vote && vote) state_nx = S_IDLE;
                else if (at_last)    state_nx = S_DATA;
            end
            S_DATA:  if (at_last && idx == 3'd7) state_nx = S_STOP;
            S_STOP:  if (at_vote) state_nx = vote ? S_IDLE : S_BREAK;
            S_BREAK: if (rxd_s) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        rx_busy   = (state != S_IDLE);
        shift_en  = (state == S_DATA) && at_vote;
        load_byte = (state == S_STOP) && at_vote && vote;
        frame_bad = (state == S_STOP) && at_vote && !vote;
    end

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            idx   <= '0;
            smp0  <= 1'b1;
            smp1  <= 1'b1;
            shreg <= '0;
        end else begin
            if (state == S_IDLE || state_nx == S_IDLE || state_nx == S_BREAK || at_last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (state == S_START && at_last) begin
                idx <= '0;
            end else if (state == S_DATA && at_last) begin
                idx <= idx + 1'b1;
            end
            if (cnt == CNT_S0) smp0 <= rxd_s;
            if (cnt == CNT_S1) smp1 <= rxd_s;
            if (shift_en) shreg <= {vote, shreg[7:1]};
        end
    end

    // A new byte landing in the same cycle as rx_read replaces the old one without overrun.
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= frame_bad;
            rx_overrun   <= 1'b0;
            if (load_byte) begin
                rx_data    <= shreg;
                rx_valid   <= 1'b1;
                rx_overrun <= rx_valid & ~rx_read;
            end else if (rx_read) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte at a short bit period; frame-level reference model
// (expected bytes, edge-count latencies, pending-byte flag) drives all checks.
module tb_uart_rx_byte;

    localparam int unsigned C         = 16;
    localparam int unsigned HALF      = C / 2;
    localparam int unsigned VALID_LAT = 4 + 9 * C + HALF;

    logic       clk_50M  = 1'b0;
    logic       reset_n  = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       rx_read  = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;

    uart_rx_byte #(.CLKS_PER_BIT(C)) dut (
        .clk_50M      (clk_50M),
        .reset_n      (reset_n),
        .uart_rxd     (uart_rxd),
        .rx_read      (rx_read),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_busy      (rx_busy)
    );

    always #5 clk_50M = ~clk_50M;
    always @(posedge clk_50M) cyc <= cyc + 1;

    // Event monitor sampled on the falling edge; cyc equals the number of the last rising edge.
    logic        prev_valid = 1'b0;
    logic        prev_busy  = 1'b0;
    int unsigned valid_rise_cyc = 0;
    int unsigned busy_fall_cyc  = 0;
    int unsigned busy_rise_cnt  = 0;
    int unsigned fe_cnt = 0, fe_cyc = 0;
    int unsigned ov_cnt = 0, ov_cyc = 0;

    always @(negedge clk_50M) begin
        if (rx_valid && !prev_valid) valid_rise_cyc = cyc;
        if (prev_busy && !rx_busy) busy_fall_cyc = cyc;
        if (rx_busy && !prev_busy) busy_rise_cnt = busy_rise_cnt + 1;
        if (rx_frame_err) begin fe_cnt = fe_cnt + 1; fe_cyc = cyc; end
        if (rx_overrun) begin ov_cnt = ov_cnt + 1; ov_cyc = cyc; end
        prev_valid = rx_valid;
        prev_busy  = rx_busy;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk_50M);
            #1;
        end
    endtask

    // Drives one 8N1 frame; spike_at (frame-relative cycle, -1 = none) inverts one cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int spike_at,
                              output int unsigned k);
        logic bitval;
        k = cyc + 1;
        for (int n = 0; n < 10; n++) begin
            for (int j = 0; j < int'(C); j++) begin
                if (n == 0) bitval = 1'b0;
                else if (n == 9) bitval = stop_bit;
                else bitval = b[n-1];
                uart_rxd = (n * int'(C) + j == spike_at) ? ~bitval : bitval;
                tick(1);
            end
        end
    endtask

    task automatic do_read();
        rx_read = 1'b1;
        tick(1);
        rx_read = 1'b0;
    endtask

    task automatic test_reset();
        int unsigned fe0, ov0, br0;
        reset_n = 1'b0; uart_rxd = 1'b1; rx_read = 1'b0;
        tick(4);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
        checks++; if ({rx_frame_err, rx_overrun} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b want 00", {rx_frame_err, rx_overrun}); end
        reset_n = 1'b1;
        fe0 = fe_cnt; ov0 = ov_cnt; br0 = busy_rise_cnt;
        tick(200);
        checks++; if (busy_rise_cnt - br0 !== 0) begin errors++; $display("FAIL idle_busy_rises: got %0d want 0", busy_rise_cnt - br0); end
        checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin errors++; $display("FAIL idle_outputs: got valid=%b data=%h want 0/00", rx_valid, rx_data); end
        checks++; if (fe_cnt - fe0 + ov_cnt - ov0 !== 0) begin errors++; $display("FAIL idle_pulses: got %0d want 0", fe_cnt - fe0 + ov_cnt - ov0); end
    endtask

    task automatic test_single_frame();
        int unsigned k, fe0;
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b1, -1, k);
        tick(4);
        checks++; if (valid_rise_cyc !== k + VALID_LAT) begin errors++; $display("FAIL single_latency: got %0d want %0d", valid_rise_cyc - k, VALID_LAT); end
        checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL single_data: got %h want 55", rx_data); end
        checks++; if (busy_fall_cyc !== k + VALID_LAT) begin errors++; $display("FAIL single_busy_fall: got %0d want %0d", busy_fall_cyc - k, VALID_LAT); end
        checks++; if (fe_cnt !== fe0) begin errors++; $display("FAIL single_frame_err: got %0d want 0", fe_cnt - fe0); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL single_valid_held: got %b want 1", rx_valid); end
        do_read();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL single_read_clear: got %b want 0", rx_valid); end
        checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL single_data_after_read: got %h want 55", rx_data); end
    endtask

    task automatic test_glitch();
        int unsigned k, fe0;
        fe0 = fe_cnt;
        k = cyc + 1;
        uart_rxd = 1'b0;
        tick(4);
        uart_rxd = 1'b1;
        tick(3 * C);
        checks++; if (busy_fall_cyc !== k + 4 + HALF) begin errors++; $display("FAIL false_start_abort: got %0d want %0d", busy_fall_cyc - k, 4 + HALF); end
        checks++; if (rx_valid !== 1'b0 || fe_cnt !== fe0 || rx_busy !== 1'b0) begin errors++; $display("FAIL false_start_flags: got valid=%b fe=%0d busy=%b want 0/0/0", rx_valid, fe_cnt - fe0, rx_busy); end
        // Spike hits the middle sample of data bit 0 (a 1); the majority keeps it 1.
        send_frame(8'hA3, 1'b1, int'(C + HALF + 1), k);
        tick(4);
        checks++; if (rx_data !== 8'hA3 || rx_valid !== 1'b1) begin errors++; $display("FAIL spike_data: got %h/%b want a3/1", rx_data, rx_valid); end
        checks++; if (valid_rise_cyc !== k + VALID_LAT) begin errors++; $display("FAIL spike_latency: got %0d want %0d", valid_rise_cyc - k, VALID_LAT); end
    endtask

    task automatic test_frame_error();
        int unsigned k, fe0, ov0, r;
        do_read();
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h3C, 1'b0, -1, k);
        tick(100);
        uart_rxd = 1'b1;
        r = cyc;
        tick(6);
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", fe_cnt - fe0); end
        checks++; if (fe_cyc !== k + VALID_LAT) begin errors++; $display("FAIL ferr_time: got %0d want %0d", fe_cyc - k, VALID_LAT); end
        checks++; if (rx_data !== 8'hA3 || rx_valid !== 1'b0) begin errors++; $display("FAIL ferr_data: got %h/%b want a3/0", rx_data, rx_valid); end
        checks++; if (busy_fall_cyc !== r + 3) begin errors++; $display("FAIL ferr_busy_release: got %0d want 3", busy_fall_cyc - r); end
        send_frame(8'h81, 1'b1, -1, k);
        tick(4);
        checks++; if (rx_data !== 8'h81 || rx_valid !== 1'b1) begin errors++; $display("FAIL after_break_data: got %h/%b want 81/1", rx_data, rx_valid); end
        checks++; if (fe_cnt - fe0 !== 1 || ov_cnt !== ov0) begin errors++; $display("FAIL after_break_flags: got fe=%0d ov=%0d want 1/0", fe_cnt - fe0, ov_cnt - ov0); end
        do_read();
    endtask

    task automatic test_back_to_back();
        int unsigned k1, k2, ov0, target;
        ov0 = ov_cnt;
        send_frame(8'h12, 1'b1, -1, k1);
        send_frame(8'h34, 1'b1, -1, k2);
        tick(4);
        checks++; if (ov_cnt - ov0 !== 1) begin errors++; $display("FAIL b2b_overrun_count: got %0d want 1", ov_cnt - ov0); end
        checks++; if (ov_cyc !== k2 + VALID_LAT) begin errors++; $display("FAIL b2b_overrun_time: got %0d want %0d", ov_cyc - k2, VALID_LAT); end
        checks++; if (rx_data !== 8'h34 || rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_data: got %h/%b want 34/1", rx_data, rx_valid); end
        do_read();
        ov0 = ov_cnt;
        target = cyc + 1 + 10 * C + VALID_LAT;
        fork
            begin
                send_frame(8'h12, 1'b1, -1, k1);
                send_frame(8'h34, 1'b1, -1, k2);
            end
            begin
                while (cyc < target - 1) tick(1);
                do_read();
            end
        join
        tick(4);
        checks++; if (ov_cnt !== ov0) begin errors++; $display("FAIL b2b_read_overrun: got %0d want 0", ov_cnt - ov0); end
        checks++; if (rx_data !== 8'h34 || rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_read_data: got %h/%b want 34/1", rx_data, rx_valid); end
        do_read();
    endtask

    task automatic test_reset_midframe();
        int unsigned k, fe0, ov0;
        logic [7:0] partial;
        partial = 8'h5A;
        uart_rxd = 1'b0;
        tick(C);
        for (int i = 0; i < 4; i++) begin
            uart_rxd = partial[i];
            tick(C);
        end
        uart_rxd = partial[4];
        tick(HALF);
        reset_n = 1'b0;
        uart_rxd = 1'b1;
        #1;
        checks++; if (rx_busy !== 1'b0 || rx_data !== 8'h00 || rx_valid !== 1'b0) begin errors++; $display("FAIL midreset_async: got busy=%b data=%h valid=%b want 0/00/0", rx_busy, rx_data, rx_valid); end
        tick(3);
        reset_n = 1'b1;
        fe0 = fe_cnt; ov0 = ov_cnt;
        tick(2 * C);
        checks++; if (rx_busy !== 1'b0 || rx_valid !== 1'b0) begin errors++; $display("FAIL midreset_idle: got busy=%b valid=%b want 0/0", rx_busy, rx_valid); end
        send_frame(8'hF0, 1'b1, -1, k);
        tick(4);
        checks++; if (rx_data !== 8'hF0 || rx_valid !== 1'b1) begin errors++; $display("FAIL midreset_next: got %h/%b want f0/1", rx_data, rx_valid); end
        checks++; if (fe_cnt !== fe0 || ov_cnt !== ov0) begin errors++; $display("FAIL midreset_flags: got fe=%0d ov=%0d want 0/0", fe_cnt - fe0, ov_cnt - ov0); end
        checks++; if (valid_rise_cyc !== k + VALID_LAT) begin errors++; $display("FAIL midreset_latency: got %0d want %0d", valid_rise_cyc - k, VALID_LAT); end
        do_read();
    endtask

    task automatic test_random();
        int unsigned k, ov0, gap;
        logic [7:0]  b;
        logic        pending;
        pending = 1'b0;
        for (int it = 0; it < 8; it++) begin
            b   = 8'($urandom_range(0, 255));
            gap = $urandom_range(0, 3 * C);
            ov0 = ov_cnt;
            send_frame(b, 1'b1, -1, k);
            tick(4);
            checks++; if (rx_data !== b || rx_valid !== 1'b1) begin errors++; $display("FAIL rand_data[%0d]: got %h/%b want %h/1", it, rx_data, rx_valid, b); end
            checks++; if (ov_cnt - ov0 !== (pending ? 1 : 0)) begin errors++; $display("FAIL rand_overrun[%0d]: got %0d want %0d", it, ov_cnt - ov0, pending ? 1 : 0); end
            if (!pending) begin
                checks++; if (valid_rise_cyc !== k + VALID_LAT) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", it, valid_rise_cyc - k, VALID_LAT); end
            end
            pending = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                do_read();
                pending = 1'b0;
                tick(2);
                do_read();
                checks++; if (rx_valid !== 1'b0 || rx_data !== b) begin errors++; $display("FAIL rand_read[%0d]: got %b/%h want 0/%h", it, rx_valid, rx_data, b); end
            end
            tick(gap);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
